ceres_prog_ctrl: RTL and testbench
==================================

Name: ceres_prog_ctrl

Overview:
- Serial programming controller between the programming UART byte receiver (fed by prog_rx_i) and the instruction/data memory write port.
- Hunts the byte stream for a 32-bit magic word, then reads a little-endian word count and the image words.
- Writes each image word to memory through a req/gnt handshake.
- Holds the core in reset and drives prog_mode_o for the whole session.

Parameters:
- MAGIC, 32'h4345_5253 ("CERS"), session start word, sent MSB byte first.
- BASE_ADDR, 32'h8000_0000, memory address of image word 0.
- MAX_WORDS, 65536, largest accepted word count.
- TIMEOUT_CYC, 1_000_000, idle cycles between bytes before a session aborts (width clog2(TIMEOUT_CYC+1)).

Ports:
- clk_i  in  1  system clock; one clock, all logic on the rising edge.
- rst_i  in  1  reset; reset is synchronous and active-high.
- rx_valid_i  in  1  one-cycle strobe, rx_data_i is a received byte.
- rx_data_i  in  8  received byte.
- mem_req_o  out  1  write request.
- mem_addr_o  out  32  word-aligned write address.
- mem_wdata_o  out  32  write data.
- mem_gnt_i  in  1  write accepted this cycle when mem_req_o=1.
- prog_mode_o  out  1  session active.
- core_rst_o  out  1  hold CPU core in reset.
- done_o  out  1  one-cycle pulse, image fully written.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset values:
  - All outputs 0; mem_addr_o/mem_wdata_o 0.
  - FSM in HUNT; shift register, counters and byte index cleared.
  - Reset mid-session aborts the session immediately with no further writes.
- HUNT:
  - Every rx byte shifts into sr = {sr[23:0], byte}.
  - When the shifted value equals MAGIC, go to LEN on the next cycle.
  - On that transition: prog_mode_o=1, core_rst_o=1 and err_o cleared. Latency is 1 cycle after the final magic byte.
- LEN:
  - Collects 4 bytes little-endian into cnt.
  - On the 4th byte: cnt==0 goes to DONE; cnt>MAX_WORDS goes to ERR; otherwise goes to DATA with idx=0.
- DATA:
  - Assembles bytes little-endian into asm[31:0] using a 2-bit byte index.
  - On the 4th byte, if no request is pending: mem_wdata_o<=asm, mem_addr_o<=BASE_ADDR+{idx,2'b00}, mem_req_o<=1 on the next cycle.
  - Byte reception continues while a request is pending. This gives one word of buffering.
  - If a 4th byte completes while mem_req_o is still high, the result is overrun and goes to ERR.
- Handshake:
  - mem_req_o, mem_addr_o and mem_wdata_o stay stable until a cycle with mem_gnt_i=1.
  - mem_req_o drops the following cycle and idx increments.
  - gnt without req is ignored.
  - When the granted word is word cnt-1, go to DONE. Any bytes after the last word are ignored until HUNT.
- DONE:
  - Lasts one cycle with done_o=1.
  - prog_mode_o=0 and core_rst_o=0 from the next cycle; returns to HUNT.
- Timeout:
  - In LEN/DATA a counter clears on each rx_valid_i and increments otherwise.
  - Reaching TIMEOUT_CYC goes to ERR. A pending request is still allowed to complete its handshake before ERR takes effect on the outputs.
- ERR:
  - err_o=1 (sticky), prog_mode_o=0, core_rst_o stays 1 so a partial image never runs, mem_req_o=0.
  - Returns to HUNT in the same cycle.
  - A new MAGIC restarts a session and clears err_o. Only rst_i or a successful DONE deasserts core_rst_o.
- Simultaneous events:
  - Timeout and rx_valid_i in the same cycle: rx_valid_i wins and the counter clears.
  - Magic detection is not active outside HUNT, so MAGIC bytes inside image data are plain data.
- Counters: idx and cnt are 32 bits wide; address arithmetic wraps mod 2^32.

Test Plan:
- Magic-byte timing: send 43 45 52 53 -> prog_mode_o=1 and core_rst_o=1 exactly one cycle after the 4th strobe; err_o=0.
- Two-word image at BASE_ADDR 8000_0000: magic, count 02 00 00 00, data 78 56 34 12 EF BE AD DE; mem_gnt_i delayed 3 cycles each -> writes (8000_0000, 1234_5678) then (8000_0004, DEAD_BEEF), each held stable until gnt; done_o one pulse; core_rst_o=0 the cycle after done_o.
- Zero-length image: magic, count 00 00 00 00 -> no mem_req_o; done_o pulse; prog_mode_o returns to 0.
- Oversized count: count 01 00 01 00 (65537) -> err_o=1, core_rst_o stays 1, no writes; a subsequent valid session clears err_o and completes.
- Overrun: mem_gnt_i tied 0 while 8 data bytes are sent back-to-back -> first request held; ERR on the 8th byte; err_o=1.
- Timeout and reset: with TIMEOUT_CYC=100, stop after 2 data bytes -> ERR exactly 100 idle cycles after the last strobe. Separately, assert rst_i mid-DATA -> all outputs 0 the next cycle and no further writes.

Source files
------------

// File: rtl/ceres_prog_ctrl.sv
// Serial programming controller. It hunts the UART byte stream for a magic
// word and then reads a little-endian word count. Image words are written to
// memory through a req/gnt port while the core is held in reset.
module ceres_prog_ctrl #(
  parameter logic [31:0] MAGIC       = 32'h4345_5253,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned MAX_WORDS   = 65536,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  output logic        prog_mode_o,
  output logic        core_rst_o,
  output logic        done_o,
  output logic        err_o
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_HUNT, S_LEN, S_DATA, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   sr_q, sr_d, cnt_q, cnt_d, asm_q, asm_d, idx_q, idx_d;
  logic [1:0]    bidx_q, bidx_d;
  logic          last_q, last_d;   // the pending request carries the final word
  logic [TW-1:0] tmo_q, tmo_d;
  logic          req_q, req_d, prog_q, prog_d, crst_q, crst_d, done_q, done_d, err_q, err_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;

  logic [31:0]   shifted, len_word, data_word;
  logic          is_last, tmo_exp, go_done, go_err;

  // Next-state logic: byte hunting, length/data assembly, handshake, timeout
  always_comb begin
    state_d = state_q;  sr_d = sr_q;  cnt_d = cnt_q;  asm_d = asm_q;
    idx_d = idx_q;  bidx_d = bidx_q;  last_d = last_q;  tmo_d = '0;
    req_d = req_q;  addr_d = addr_q;  wdata_d = wdata_q;
    prog_d = prog_q;  crst_d = crst_q;  done_d = 1'b0;  err_d = err_q;
    go_done = 1'b0;  go_err = 1'b0;

    shifted   = {sr_q[23:0], rx_data_i};
    len_word  = {rx_data_i, cnt_q[31:8]};
    data_word = {rx_data_i, asm_q[31:8]};
    is_last   = (idx_q == cnt_q - 32'd1);
    // a byte arriving in the expiry cycle wins over the timeout
    tmo_exp   = !rx_valid_i && (tmo_q >= TMO_LAST);

    if (state_q == S_LEN || state_q == S_DATA)
      tmo_d = rx_valid_i ? '0 : ((tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1));

    case (state_q)
      S_HUNT: begin
        if (rx_valid_i) begin
          sr_d = shifted;
          if (shifted == MAGIC) begin
            state_d = S_LEN;
            prog_d  = 1'b1;
            crst_d  = 1'b1;
            err_d   = 1'b0;
            sr_d    = '0;
            cnt_d   = '0;
            bidx_d  = '0;
          end
        end
      end
      S_LEN: begin
        if (rx_valid_i) begin
          cnt_d  = len_word;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            if (len_word == 32'd0)                go_done = 1'b1;
            else if (len_word > 32'(MAX_WORDS))   go_err  = 1'b1;
            else begin
              state_d = S_DATA;
              idx_d   = '0;
              last_d  = 1'b0;
            end
          end
        end else if (tmo_exp) begin
          go_err = 1'b1;
        end
      end
      S_DATA: begin
        if (req_q && mem_gnt_i && is_last) begin
          go_done = 1'b1;
        end else begin
          if (req_q && mem_gnt_i) begin
            req_d = 1'b0;
            idx_d = idx_q + 32'd1;
          end
          // bytes beyond the final word are dropped
          if (rx_valid_i && !last_q) begin
            asm_d  = data_word;
            bidx_d = bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              if (req_q) go_err = 1'b1;  // second word done while first still waits
              else begin
                req_d   = 1'b1;
                wdata_d = data_word;
                addr_d  = BASE_ADDR + {idx_q[29:0], 2'b00};
                last_d  = is_last;
              end
            end
          end else if (tmo_exp && (!req_q || mem_gnt_i)) begin
            // an outstanding request finishes its handshake first
            go_err = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_HUNT;
        prog_d  = 1'b0;
        crst_d  = 1'b0;
      end
      default: state_d = S_HUNT;
    endcase

    if (go_done) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      req_d   = 1'b0;
    end
    // core_rst stays high so a partial image never runs
    if (go_err) begin
      state_d = S_HUNT;
      err_d   = 1'b1;
      prog_d  = 1'b0;
      req_d   = 1'b0;
      sr_d    = '0;
    end
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_HUNT;  sr_q <= '0;  cnt_q <= '0;  asm_q <= '0;  idx_q <= '0;
      bidx_q <= '0;  last_q <= 1'b0;  tmo_q <= '0;
      req_q <= 1'b0;  addr_q <= '0;  wdata_q <= '0;
      prog_q <= 1'b0;  crst_q <= 1'b0;  done_q <= 1'b0;  err_q <= 1'b0;
    end else begin
      state_q <= state_d;  sr_q <= sr_d;  cnt_q <= cnt_d;  asm_q <= asm_d;  idx_q <= idx_d;
      bidx_q <= bidx_d;  last_q <= last_d;  tmo_q <= tmo_d;
      req_q <= req_d;  addr_q <= addr_d;  wdata_q <= wdata_d;
      prog_q <= prog_d;  crst_q <= crst_d;  done_q <= done_d;  err_q <= err_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign prog_mode_o = prog_q;
  assign core_rst_o  = crst_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_ceres_prog_ctrl.sv
// Directed bench for ceres_prog_ctrl: vector table plus multi-cycle sequences.
module tb_ceres_prog_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        gnt = 1'b0;
  logic        req, prog, crst, done, err;
  logic [31:0] addr, wdata;

  int n_vec = 0;
  int n_bad = 0;

  ceres_prog_ctrl #(.TIMEOUT_CYC(100)) dut (
    .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .mem_req_o(req), .mem_addr_o(addr), .mem_wdata_o(wdata), .mem_gnt_i(gnt),
    .prog_mode_o(prog), .core_rst_o(crst), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       g;
    logic [4:0] exp;  // {req, prog, core_rst, done, err}
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] d, input logic g, input logic [4:0] e);
    vec_t x;
    x.v = v; x.d = d; x.g = g; x.exp = e;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // one cycle: drive, clock, then sit 1ns after the edge
  task automatic step(input logic v, input logic [7:0] d, input logic g);
    rx_valid = v; rx_data = d; gnt = g;
    @(posedge clk); #1;
    rx_valid = 1'b0; gnt = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic magic_and_count(input logic [31:0] c);
    send(8'h43); send(8'h45); send(8'h52); send(8'h53);
    send(c[7:0]); send(c[15:8]); send(c[23:16]); send(c[31:24]);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", {27'd0, req, prog, crst, done, err}, 32'd0);
    chk("reset_addr", addr, 32'd0);
    chk("reset_wdata", wdata, 32'd0);
    rst = 1'b0;

    // magic timing, zero-length image, oversized count, one-word session
    add(1, 8'h43, 0, 5'b00000); add(1, 8'h45, 0, 5'b00000);
    add(1, 8'h52, 0, 5'b00000); add(1, 8'h53, 0, 5'b01100);
    add(1, 8'h00, 0, 5'b01100); add(1, 8'h00, 0, 5'b01100);
    add(1, 8'h00, 0, 5'b01100); add(1, 8'h00, 0, 5'b01110);
    add(0, 8'h00, 0, 5'b00000);
    add(1, 8'h43, 0, 5'b00000); add(1, 8'h45, 0, 5'b00000);
    add(1, 8'h52, 0, 5'b00000); add(1, 8'h53, 0, 5'b01100);
    add(1, 8'h01, 0, 5'b01100); add(1, 8'h00, 0, 5'b01100);
    add(1, 8'h01, 0, 5'b01100); add(1, 8'h00, 0, 5'b00101);
    add(0, 8'h00, 0, 5'b00101);
    add(1, 8'h43, 0, 5'b00101); add(1, 8'h45, 0, 5'b00101);
    add(1, 8'h52, 0, 5'b00101); add(1, 8'h53, 0, 5'b01100);
    add(1, 8'h01, 0, 5'b01100); add(1, 8'h00, 0, 5'b01100);
    add(1, 8'h00, 0, 5'b01100); add(1, 8'h00, 0, 5'b01100);
    add(1, 8'h11, 0, 5'b01100); add(1, 8'h22, 0, 5'b01100);
    add(1, 8'h33, 0, 5'b01100); add(1, 8'h44, 0, 5'b11100);
    add(0, 8'h00, 1, 5'b01110);
    add(0, 8'h00, 0, 5'b00000);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].g);
      chk($sformatf("vec%0d", i), {27'd0, req, prog, crst, done, err}, {27'd0, tbl[i].exp});
    end

    // two-word image, grant delayed three cycles per word
    magic_and_count(32'd2);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    for (int c = 0; c < 3; c++) begin
      chk("w0_req", {31'd0, req}, 32'd1);
      chk("w0_addr", addr, 32'h8000_0000);
      chk("w0_data", wdata, 32'h1234_5678);
      step(1'b0, 8'h00, 1'b0);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("w0_drop", {31'd0, req}, 32'd0);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    for (int c = 0; c < 3; c++) begin
      chk("w1_req", {31'd0, req}, 32'd1);
      chk("w1_addr", addr, 32'h8000_0004);
      chk("w1_data", wdata, 32'hDEAD_BEEF);
      step(1'b0, 8'h00, 1'b0);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("w1_done", {29'd0, req, done, crst}, {29'd0, 3'b011});
    step(1'b0, 8'h00, 1'b0);
    chk("after_done", {29'd0, done, crst, prog}, 32'd0);

    // overrun: grant held low while two words arrive
    magic_and_count(32'd2);
    for (int b = 0; b < 7; b++) begin
      send(8'(8'h10 + b));
      if (b >= 3) chk("ovr_hold", {req, addr[30:0]}, {1'b1, 31'h0000_0000});
    end
    send(8'h17);
    chk("ovr_err", {28'd0, req, prog, crst, err}, {28'd0, 4'b0011});

    // timeout: two data bytes then silence
    magic_and_count(32'd2);
    chk("tmo_errclr", {31'd0, err}, 32'd0);
    send(8'hAA); send(8'hBB);
    for (int c = 1; c <= 99; c++) step(1'b0, 8'h00, 1'b0);
    chk("tmo_99", {30'd0, err, prog}, {30'd0, 2'b01});
    step(1'b0, 8'h00, 1'b0);
    chk("tmo_100", {30'd0, err, prog, crst}, {29'd0, 3'b101});

    // reset in the middle of a write
    magic_and_count(32'd3);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("rst_pre_req", {31'd0, req}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_flags", {27'd0, req, prog, crst, done, err}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    for (int b = 0; b < 6; b++) begin
      step(1'b1, 8'(8'h05 + b), 1'b1);
      chk("rst_no_write", {31'd0, req}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
